// File: rtl/cdma_despreader.sv
// Gold-code despreader: local 31-chip code generator, per-symbol mismatch count,
// and an IDLE/ACQUIRE/TRACK loop that slips the local code one chip per bad symbol.

module cdma_despreader #(
  parameter int CHIP_DIV = 4,
  parameter int THRESH   = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       chip_i,
  input  logic [4:0] seed_i,
  input  logic       load_i,
  output logic       data_o,
  output logic       valid_o,
  output logic       lock_o
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

  localparam logic [7:0] TICK_MAX = 8'(CHIP_DIV - 1);
  localparam logic [4:0] LAST_IDX = 5'd30;
  localparam logic [4:0] ONE_MIN  = 5'(31 - THRESH);
  localparam logic [4:0] ZERO_MAX = 5'(THRESH);
  localparam logic [4:0] A_INIT   = 5'b00001;
  localparam logic [4:0] B_INIT   = 5'b11111;

  function automatic logic [4:0] step_a(input logic [4:0] v);
    return {v[3:0], v[4] ^ v[1]};
  endfunction

  function automatic logic [4:0] step_b(input logic [4:0] v);
    return {v[3:0], v[4] ^ v[3] ^ v[2] ^ v[1]};
  endfunction

  state_t     state, state_nx;
  logic [4:0] lfsr_a, lfsr_a_nx;
  logic [4:0] lfsr_b, lfsr_b_nx;
  logic [7:0] tick, tick_nx;
  logic [4:0] chip_idx, chip_idx_nx;
  logic [4:0] ones, ones_nx;
  logic [1:0] streak, streak_nx;
  logic       slip, slip_nx;
  logic       data_nx, valid_nx;

  logic       gold, mism, strobe, sym_end;
  logic [4:0] total;
  logic       sym_one, sym_zero, sym_good;

  // The ones count never exceeds 30 before the last chip, so 5 bits hold the total.
  assign gold     = lfsr_a[4] ^ lfsr_b[4];
  assign mism     = chip_i ^ gold;
  assign strobe   = (state != IDLE) && (tick == TICK_MAX);
  assign sym_end  = strobe && (chip_idx == LAST_IDX);
  assign total    = ones + {4'b0000, mism};
  assign sym_one  = (total >= ONE_MIN);
  assign sym_zero = (total <= ZERO_MAX);
  assign sym_good = sym_one || sym_zero;
  assign lock_o   = (state == TRACK);

  always_comb begin
    state_nx    = state;
    lfsr_a_nx   = lfsr_a;
    lfsr_b_nx   = lfsr_b;
    tick_nx     = tick;
    chip_idx_nx = chip_idx;
    ones_nx     = ones;
    streak_nx   = streak;
    slip_nx     = slip;
    data_nx     = data_o;
    valid_nx    = 1'b0;

    if (load_i) begin
      lfsr_a_nx   = (seed_i == 5'd0) ? A_INIT : seed_i;
      lfsr_b_nx   = B_INIT;
      tick_nx     = 8'd0;
      chip_idx_nx = 5'd0;
      ones_nx     = 5'd0;
      streak_nx   = 2'd0;
      slip_nx     = 1'b0;
      state_nx    = ACQUIRE;
    end else if (state != IDLE) begin
      tick_nx = (tick == TICK_MAX) ? 8'd0 : tick + 8'd1;
      if (strobe) begin
        // A pending slip holds the code for one chip, delaying it by one chip.
        if (!slip) begin
          lfsr_a_nx = step_a(lfsr_a);
          lfsr_b_nx = step_b(lfsr_b);
        end
        slip_nx = 1'b0;
        if (sym_end) begin
          chip_idx_nx = 5'd0;
          ones_nx     = 5'd0;
          if (state == TRACK) begin
            if (sym_good) begin
              data_nx  = sym_one;
              valid_nx = 1'b1;
            end else begin
              state_nx  = ACQUIRE;
              streak_nx = 2'd0;
              slip_nx   = 1'b1;
            end
          end else begin
            if (sym_good) begin
              streak_nx = streak + 2'd1;
              if (streak_nx == 2'd2) begin
                state_nx  = TRACK;
                streak_nx = 2'd0;
              end
            end else begin
              streak_nx = 2'd0;
              slip_nx   = 1'b1;
            end
          end
        end else begin
          chip_idx_nx = chip_idx + 5'd1;
          ones_nx     = total;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      lfsr_a   <= A_INIT;
      lfsr_b   <= B_INIT;
      tick     <= 8'd0;
      chip_idx <= 5'd0;
      ones     <= 5'd0;
      streak   <= 2'd0;
      slip     <= 1'b0;
      data_o   <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      state    <= state_nx;
      lfsr_a   <= lfsr_a_nx;
      lfsr_b   <= lfsr_b_nx;
      tick     <= tick_nx;
      chip_idx <= chip_idx_nx;
      ones     <= ones_nx;
      streak   <= streak_nx;
      slip     <= slip_nx;
      data_o   <= data_nx;
      valid_o  <= valid_nx;
    end
  end

endmodule

// File: tb/tb_cdma_despreader.sv
// Bench for cdma_despreader: a chip-level transmitter model drives spread data,
// and a symbol-level reference predicts data_o/valid_o/lock_o every cycle.

module tb_cdma_despreader;

  localparam int CD = 4;
  localparam int TH = 5;
  localparam int M_IDLE  = 0;
  localparam int M_ACQ   = 1;
  localparam int M_TRACK = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       chip_i = 1'b0;
  logic [4:0] seed_i = 5'd0;
  logic       load_i = 1'b0;
  logic       data_o, valid_o, lock_o;

  cdma_despreader #(.CHIP_DIV(CD), .THRESH(TH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .chip_i(chip_i), .seed_i(seed_i),
    .load_i(load_i), .data_o(data_o), .valid_o(valid_o), .lock_o(lock_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cyc   = 0;
  int load_base = 0;

  always @(posedge clk_i) tb_cyc <= tb_cyc + 1;

  // Transmitter configuration
  logic [30:0] tx_code = '0;
  int          tx_delay = 0;
  bit          tx_bits[64];
  int          inv_sym_a = -100, inv_cnt_a = 0;
  int          inv_sym_b = -100, inv_cnt_b = 0;

  // Reference model state
  bit          model_ready = 1'b0;
  int          md_mode = M_IDLE;
  int          md_t, md_n, md_ones, md_streak, md_slips;
  bit          md_slip;
  logic [30:0] md_code = '0;
  bit          exp_data = 1'b0, exp_valid = 1'b0;
  logic        exp_lock;
  bit          good_one, good_zero;

  assign exp_lock = (md_mode == M_TRACK);

  // Observed events, relative to the last load release
  int dv_t[$];
  bit dv_d[$];
  int dut_lock_t = -1, mdl_lock_t = -1;
  bit prev_lock = 1'b0, prev_mlock = 1'b0;

  // Chip k of the code produced by a generator loaded with this seed.
  function automatic logic [30:0] gold_code(input logic [4:0] seed);
    logic [4:0]  a, b;
    logic [30:0] c;
    a = (seed == 5'd0) ? 5'd1 : seed;
    b = 5'h1f;
    c = '0;
    for (int k = 0; k < 31; k++) begin
      c[k] = a[4] ^ b[4];
      a = {a[3:0], a[4] ^ a[1]};
      b = {b[3:0], b[4] ^ b[3] ^ b[2] ^ b[1]};
    end
    return c;
  endfunction

  // Chip on the wire; off-strobe cycles carry noise the DUT must ignore.
  function automatic logic tx_chip();
    int   n, kk, ph, sym;
    logic c;
    if (md_mode == M_IDLE || (md_t % CD) != CD - 1) return 1'($urandom_range(0, 1));
    n   = md_t / CD;
    kk  = n - tx_delay + 31 * 8;
    ph  = kk % 31;
    sym = kk / 31 - 8;
    c   = tx_code[ph] ^ ((sym < 0) ? 1'b1 : tx_bits[sym % 64]);
    if ((sym == inv_sym_a && ph < inv_cnt_a) || (sym == inv_sym_b && ph < inv_cnt_b)) c = ~c;
    return c;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int getT(input int i);
    return (i < dv_t.size()) ? dv_t[i] : -1;
  endfunction

  function automatic int getD(input int i);
    return (i < dv_d.size()) ? int'(dv_d[i]) : -1;
  endfunction

  // Symbol-level reference: code phase is the chip number minus the slips taken so far.
  initial begin
    forever begin
      @(posedge clk_i);
      if (rst_i) begin
        md_mode = M_IDLE; md_t = 0; md_ones = 0; md_streak = 0; md_slips = 0;
        md_slip = 1'b0; exp_data = 1'b0; exp_valid = 1'b0; model_ready = 1'b1;
      end else if (load_i) begin
        md_code = gold_code(seed_i);
        md_mode = M_ACQ; md_t = 0; md_ones = 0; md_streak = 0; md_slips = 0;
        md_slip = 1'b0; exp_valid = 1'b0;
      end else begin
        exp_valid = 1'b0;
        if (md_mode != M_IDLE) begin
          if ((md_t % CD) == CD - 1) begin
            md_n = md_t / CD;
            if (chip_i != md_code[(md_n - md_slips) % 31]) md_ones++;
            if (md_slip) begin md_slips++; md_slip = 1'b0; end
            if ((md_n % 31) == 30) begin
              good_one  = (md_ones >= 31 - TH);
              good_zero = (md_ones <= TH);
              if (md_mode == M_TRACK) begin
                if (good_one || good_zero) begin
                  exp_data = good_one; exp_valid = 1'b1;
                end else begin
                  md_mode = M_ACQ; md_streak = 0; md_slip = 1'b1;
                end
              end else if (good_one || good_zero) begin
                md_streak++;
                if (md_streak == 2) begin md_mode = M_TRACK; md_streak = 0; end
              end else begin
                md_streak = 0; md_slip = 1'b1;
              end
              md_ones = 0;
            end
          end
          md_t++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1 chip_i = tx_chip();
    end
  end

  // Per-cycle compare and event capture
  initial begin
    forever begin
      @(negedge clk_i);
      if (model_ready) begin
        checkOutput("valid_o", int'(valid_o), int'(exp_valid));
        checkOutput("lock_o",  int'(lock_o),  int'(exp_lock));
        checkOutput("data_o",  int'(data_o),  int'(exp_data));
        if (valid_o === 1'b1) begin
          dv_t.push_back(tb_cyc - load_base);
          dv_d.push_back(data_o);
        end
        if (lock_o === 1'b1 && !prev_lock && dut_lock_t < 0) dut_lock_t = tb_cyc - load_base;
        if (exp_lock === 1'b1 && !prev_mlock && mdl_lock_t < 0) mdl_lock_t = tb_cyc - load_base;
        prev_lock  = (lock_o === 1'b1);
        prev_mlock = (exp_lock === 1'b1);
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] seed, input logic [4:0] code_seed, input int delay);
    @(posedge clk_i);
    #1 seed_i = seed; load_i = 1'b1;
    @(posedge clk_i);
    #1 load_i = 1'b0;
    load_base = tb_cyc;
    tx_code   = gold_code(code_seed);
    tx_delay  = delay;
    dv_t.delete(); dv_d.delete();
    dut_lock_t = -1; mdl_lock_t = -1;
  endtask

  task automatic waitRel(input int target);
    @(negedge clk_i);
    while ((tb_cyc - load_base) < target) @(negedge clk_i);
  endtask

  task automatic randomBits();
    for (int i = 0; i < 64; i++) tx_bits[i] = 1'($urandom_range(0, 1));
  endtask

  logic [30:0] pin;

  initial begin
    // Reset
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_data",  int'(data_o),  0);
    checkOutput("reset_valid", int'(valid_o), 0);
    checkOutput("reset_lock",  int'(lock_o),  0);
    pin = gold_code(5'd0);
    checkOutput("gold_first5", int'(pin[4:0]), 5'b01111);

    // Aligned stream, seed 13, symbols 3..6 carry 1,0,1,1
    randomBits();
    tx_bits[0] = 1; tx_bits[1] = 1; tx_bits[2] = 1; tx_bits[3] = 0; tx_bits[4] = 1; tx_bits[5] = 1;
    applyStimulus(5'h13, 5'h13, 0);
    waitRel(800);
    checkOutput("s1_lock_time", dut_lock_t, 248);
    checkOutput("s1_model_lock_time", mdl_lock_t, 248);
    checkOutput("s1_valid_count", dv_t.size(), 4);
    checkOutput("s1_v0_t", getT(0), 372); checkOutput("s1_v0_d", getD(0), 1);
    checkOutput("s1_v1_t", getT(1), 496); checkOutput("s1_v1_d", getD(1), 0);
    checkOutput("s1_v2_t", getT(2), 620); checkOutput("s1_v2_d", getD(2), 1);
    checkOutput("s1_v3_t", getT(3), 744); checkOutput("s1_v3_d", getD(3), 1);

    // Stream 3 chips late: three slips, then lock after two good symbols
    randomBits();
    for (int i = 0; i < 8; i++) tx_bits[i] = 1;
    applyStimulus(5'h0B, 5'h0B, 3);
    waitRel(624);
    checkOutput("s2_lock_time", dut_lock_t, 620);
    checkOutput("s2_model_lock_time", mdl_lock_t, 620);
    checkOutput("s2_no_valid_before_lock", dv_t.size(), 0);

    // Tracking: 5 inverted chips tolerated, 6 drop lock
    randomBits();
    inv_sym_a = 3; inv_cnt_a = 5;
    inv_sym_b = 5; inv_cnt_b = 6;
    applyStimulus(5'h1A, 5'h1A, 0);
    waitRel(743);
    checkOutput("s3_locked_before", int'(lock_o), 1);
    waitRel(744);
    checkOutput("s3_valid_bad_sym", int'(valid_o), 0);
    checkOutput("s3_lock_dropped", int'(lock_o), 0);
    checkOutput("s3_valid_count", dv_t.size(), 3);
    checkOutput("s3_inv5_t", getT(1), 496);
    checkOutput("s3_inv5_d", getD(1), int'(tx_bits[3]));
    inv_sym_a = -100; inv_cnt_a = 0; inv_sym_b = -100; inv_cnt_b = 0;

    // Load coinciding with the symbol-end strobe while tracking
    randomBits();
    applyStimulus(5'h07, 5'h07, 0);
    waitRel(494);
    checkOutput("s4_locked", int'(lock_o), 1);
    applyStimulus(5'h07, 5'h07, 0);
    @(negedge clk_i);
    checkOutput("s4_no_valid", int'(valid_o), 0);
    checkOutput("s4_lock_low", int'(lock_o), 0);
    waitRel(250);
    checkOutput("s4_relock_time", dut_lock_t, 248);

    // Seed 0 behaves as seed 1
    randomBits();
    tx_bits[2] = 1;
    applyStimulus(5'h00, 5'h01, 0);
    waitRel(400);
    checkOutput("s5_lock_time", dut_lock_t, 248);
    checkOutput("s5_valid_count", dv_t.size(), 1);
    checkOutput("s5_v0_d", getD(0), 1);

    // Reset together with load, mid-symbol
    @(posedge clk_i);
    #1 rst_i = 1'b1; load_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0; load_i = 1'b0;
    @(negedge clk_i);
    checkOutput("s6_data", int'(data_o), 0);
    checkOutput("s6_valid", int'(valid_o), 0);
    checkOutput("s6_lock", int'(lock_o), 0);
    repeat (150) @(negedge clk_i);
    checkOutput("s6_still_idle", int'(lock_o), 0);

    // Randomized loads, offsets and chip errors against the model
    for (int r = 0; r < 4; r++) begin
      logic [4:0] s;
      randomBits();
      s = 5'($urandom_range(0, 31));
      inv_sym_a = $urandom_range(1, 8);
      inv_cnt_a = $urandom_range(0, 8);
      applyStimulus(s, s, $urandom_range(0, 30));
      repeat (700) @(negedge clk_i);
      if (r == 2) begin
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
      end
      repeat (800) @(negedge clk_i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdma_despreader.md
CDMA_DESPREADER -- requirements
Module: cdma_despreader

Interface
REQ-001 SHALL have parameter CHIP_DIV, default 4: clock cycles per chip, legal range 2..255.
REQ-002 SHALL have parameter THRESH, default 5: maximum mismatching chips per symbol for a valid decision.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic rises on its positive edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port chip_i, input, 1: received spread chip stream, chip = data XOR gold.
REQ-006 SHALL have port seed_i, input, 5: seed for LFSR A, captured on load.
REQ-007 SHALL have port load_i, input, 1: level-sensitive load and restart command.
REQ-008 SHALL have port data_o, output, 1: last despread data bit.
REQ-009 SHALL have port valid_o, output, 1: one-cycle pulse when data_o is updated.
REQ-010 SHALL have port lock_o, output, 1: high while in TRACK.

Function
REQ-011 SHALL implement LFSR A as a 5-bit Fibonacci register, x^5+x^2+1: feedback = a[4]^a[1], shift left, feedback into a[0].
REQ-012 SHALL implement LFSR B as x^5+x^4+x^3+x^2+1: feedback = b[4]^b[3]^b[2]^b[1], same shift.
REQ-013 SHALL produce local gold chip g = a[4]^b[4], with period 31 chips.
REQ-014 SHALL, on load, set A = seed_i (5'b00001 if seed_i == 0) and B = 5'b11111.
REQ-015 SHALL run a tick counter 0..CHIP_DIV-1, free-running outside IDLE.
REQ-016 SHALL sample chip_i on each cycle where tick == CHIP_DIV-1 (chip strobe).
REQ-017 SHALL, on each chip strobe, compute m = chip_i XOR g and add m to a 5-bit ones count.
REQ-018 SHALL advance both LFSRs on each chip strobe, except on a slip strobe (REQ-024).
REQ-019 SHALL, on every chip strobe, advance chip index 0..30 and wrap 30->0; the strobe at index 30 is the symbol end.
REQ-020 SHALL, at symbol end, define total ones = ones count including the current m:
- total >= 31-THRESH: good symbol, bit = 1
- total <= THRESH: good symbol, bit = 0
- otherwise: bad symbol
REQ-021 SHALL clear the ones count at each symbol end.
REQ-022 SHALL implement states IDLE, ACQUIRE, TRACK.
- IDLE: after reset; counters held at 0; waits for load_i.
- Any state with load_i = 1: reload per REQ-014, clear tick, index, count and good-streak, go to ACQUIRE.
REQ-023 SHALL, in ACQUIRE, count consecutive good symbols (2-bit streak):
- streak reaching 2: go to TRACK
- bad symbol: clear streak
REQ-024 SHALL, on a bad symbol in ACQUIRE, arm a slip: the next chip strobe does not advance the LFSRs (one-chip phase shift) but still counts chip_i.
REQ-025 SHALL, in TRACK, on each good symbol set data_o = bit and pulse valid_o for exactly one cycle, the cycle after the symbol-end strobe.
REQ-026 SHALL, in TRACK, on a bad symbol go to ACQUIRE, drop lock_o the next cycle, clear streak and arm a slip, with no valid_o.
REQ-027 SHALL NOT pulse valid_o in IDLE or ACQUIRE; this includes the symbol that completes acquisition.
REQ-028 SHALL give load_i priority over a coincident symbol end: no valid_o, no state decision.
REQ-029 SHALL hold data_o between valid_o pulses.

Reset
REQ-030 SHALL, with rst_i high at a clock edge, set state = IDLE, A = 5'b00001, B = 5'b11111, tick/index/count/streak = 0, slip disarmed, data_o = 0, valid_o = 0, lock_o = 0.
REQ-031 SHALL give rst_i priority over load_i; reset mid-symbol discards the partial count.

Verification
REQ-032 SHALL cover: reset, seed 5'h13 loaded, chips = bits 1,0,1,1 spread aligned with the same code -> lock_o high after symbol 2; valid_o pulses carry 1, 0, 1, 1 for symbols 3..6, each pulse 1 cycle, spaced 31*CHIP_DIV cycles.
REQ-033 SHALL cover: stream delayed by 3 chips after load -> 3 slips in ACQUIRE, then lock_o within 3 bad + 2 good symbols; no valid_o before lock.
REQ-034 SHALL cover: in TRACK, 5 chips inverted in one symbol -> still valid (THRESH = 5); 6 inverted -> no valid_o, lock_o falls, state ACQUIRE.
REQ-035 SHALL cover: load_i asserted on the symbol-end strobe while in TRACK -> no valid_o, lock_o = 0, counters cleared.
REQ-036 SHALL cover: seed_i = 0 loaded -> behaviour identical to seed 5'h01.
REQ-037 SHALL cover: rst_i asserted mid-symbol with load_i also high -> all outputs 0, state IDLE next cycle.
